// File: rtl/rgb_channel_controller.sv
`default_nettype none
// ============================================================================
// Module      : rgb_channel_controller
// Description : Quadrature encoder + push-button front end driving three
//               8-bit RGB channel registers (short press = select, long = clear).
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_channel_controller #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int LONG_CYCLES     = 2000000,
    parameter int STEP            = 1,
    parameter int SATURATE        = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       btn,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [1:0] sel,
    output logic       sel_pulse,
    output logic       clr_pulse
);

    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_LONG_LAST = c_HOLD_W'(LONG_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_LONG_MAX  = c_HOLD_W'(LONG_CYCLES);
    localparam logic [8:0]          c_STEP9     = 9'(STEP);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    logic [1:0]          r_a_sync;
    logic [1:0]          r_b_sync;
    logic [1:0]          r_btn_sync;
    logic                r_old_a;
    logic                r_old_b;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic                r_btn_db;
    state_t              r_state;
    state_t              w_state_next;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_next;
    logic                w_sel_adv;
    logic                w_clr;
    logic [7:0]          r_chan [3];
    logic [1:0]          r_sel;
    logic                r_sel_pulse;
    logic                r_clr_pulse;

    logic       w_a;
    logic       w_b;
    logic [3:0] w_pat;
    logic       w_inc;
    logic       w_dec;
    logic [7:0] w_cur;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_new;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sync   <= 2'b00;
            r_b_sync   <= 2'b00;
            r_btn_sync <= 2'b00;
            r_old_a    <= 1'b0;
            r_old_b    <= 1'b0;
        end else begin
            r_a_sync   <= {r_a_sync[0], enc_a};
            r_b_sync   <= {r_b_sync[0], enc_b};
            r_btn_sync <= {r_btn_sync[0], btn};
            r_old_a    <= r_a_sync[1];
            r_old_b    <= r_b_sync[1];
        end
    end

    assign w_a   = r_a_sync[1];
    assign w_b   = r_b_sync[1];
    assign w_pat = {w_a, r_old_a, w_b, r_old_b};
    assign w_inc = (w_pat == 4'b1000) || (w_pat == 4'b0111);
    assign w_dec = (w_pat == 4'b0010) || (w_pat == 4'b1101);

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_cnt <= '0;
            r_btn_db <= 1'b0;
        end else if (r_btn_sync[1] == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_db_cnt <= '0;
            r_btn_db <= ~r_btn_db;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_sel_adv    = 1'b0;
        w_clr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_btn_db) begin
                    w_state_next = S_PRESSED;
                    w_hold_next  = '0;
                end
            end
            S_PRESSED: begin
                if (!r_btn_db) begin
                    w_sel_adv    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_hold >= c_LONG_LAST) begin
                    w_clr        = 1'b1;
                    w_hold_next  = c_LONG_MAX;
                    w_state_next = S_HELD;
                end else begin
                    w_hold_next = r_hold + 1'b1;
                end
            end
            S_HELD: begin
                if (!r_btn_db) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_sel)
            2'd1:    w_cur = r_chan[1];
            2'd2:    w_cur = r_chan[2];
            default: w_cur = r_chan[0];
        endcase
    end

    // 9-bit arithmetic: bit 8 flags overflow on increment, borrow on decrement
    assign w_sum  = {1'b0, w_cur} + c_STEP9;
    assign w_diff = {1'b0, w_cur} - c_STEP9;

    always_comb begin
        w_new = w_cur;
        if (w_inc) begin
            w_new = ((SATURATE != 0) && w_sum[8]) ? 8'hFF : w_sum[7:0];
        end else if (w_dec) begin
            w_new = ((SATURATE != 0) && w_diff[8]) ? 8'h00 : w_diff[7:0];
        end
    end

    // Step and clear both target the selection held before any same-cycle sel advance
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                r_chan[i] <= 8'h00;
            end
            r_sel       <= 2'd0;
            r_sel_pulse <= 1'b0;
            r_clr_pulse <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sel == 2'(i)) begin
                    if (w_clr) begin
                        r_chan[i] <= 8'h00;
                    end else if (w_inc || w_dec) begin
                        r_chan[i] <= w_new;
                    end
                end
            end
            if (w_sel_adv) begin
                r_sel <= (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
            end
            r_sel_pulse <= w_sel_adv;
            r_clr_pulse <= w_clr;
        end
    end

    assign red       = r_chan[0];
    assign green     = r_chan[1];
    assign blue      = r_chan[2];
    assign sel       = r_sel;
    assign sel_pulse = r_sel_pulse;
    assign clr_pulse = r_clr_pulse;

endmodule
`default_nettype wire
